nn_bus_master: RTL and testbench

NN_BUS_MASTER -- requirements
Module: nn_bus_master

---
 rtl/nn_bus_master.sv | 114 +++++++++++
 tb/tb_nn_bus_master.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/nn_bus_master.sv
// NN bus master: accepts read/write commands, drives the NN bus strobe and
// fields with one-cycle latency, and collects pushed-out results in a FIFO.
module nn_bus_master #(
  parameter int ADDR_W    = 20,
  parameter int DATA_W    = 32,
  parameter int RES_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_rw,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              RW,
  output logic              sel,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] din,
  input  logic [DATA_W-1:0] dout,
  input  logic              bus_stop,
  input  logic              pushout,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic              res_overflow,
  output logic              busy
);

  localparam int PW = $clog2(RES_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {IDLE, DRIVE} state_t;

  state_t state_q, state_d;

  logic [DATA_W-1:0] mem [RES_DEPTH];
  logic [PW-1:0]     rd_ptr, wr_ptr;
  logic [CW-1:0]     res_count;
  logic              space_ok;
  logic              accept;
  logic              fifo_full;
  logic              pop, push;

  assign fifo_full = (res_count == CW'(RES_DEPTH));
  // Keep two free slots so results of the in-flight and next command fit.
  assign space_ok  = (CW'(RES_DEPTH) - res_count) >= CW'(2);
  // Reset gating keeps cmd_ready low while reset is held.
  assign cmd_ready = !reset && space_ok &&
                     ((state_q == IDLE) || ((state_q == DRIVE) && !bus_stop));
  assign accept    = cmd_valid && cmd_ready;

  assign res_valid = (res_count != '0);
  assign res_data  = mem[rd_ptr];
  assign pop       = res_ready && res_valid;
  assign push      = pushout && (!fifo_full || pop);
  assign busy      = (state_q == DRIVE) || res_valid;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state: a new command always (re)enters DRIVE; completion drops to IDLE.
  always_comb begin
    state_d = state_q;
    if (accept)
      state_d = DRIVE;
    else if ((state_q == DRIVE) && !bus_stop)
      state_d = IDLE;
  end

  // Registered NN bus outputs; fields hold across stalls and after completion.
  always_ff @(posedge clk) begin
    if (reset) begin
      sel  <= 1'b0;
      RW   <= 1'b0;
      addr <= '0;
      din  <= '0;
    end else if (accept) begin
      sel  <= 1'b1;
      RW   <= cmd_rw;
      addr <= cmd_addr;
      din  <= cmd_rw ? cmd_data : '0;
    end else if ((state_q == DRIVE) && !bus_stop) begin
      sel  <= 1'b0;
    end
  end

  // Result FIFO storage.
  always_ff @(posedge clk) begin
    if (!reset && push) mem[wr_ptr] <= dout;
  end

  // Result FIFO pointers, occupancy and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      res_count    <= '0;
      res_overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   res_count <= res_count + 1'b1;
        2'b01:   res_count <= res_count - 1'b1;
        default: res_count <= res_count;
      endcase
      if (pushout && fifo_full && !pop) res_overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_nn_bus_master.sv
// Testbench for nn_bus_master: directed scenarios plus randomized traffic,
// checked against a transaction-level reference model.
module tb_nn_bus_master;

  localparam int ADDR_W    = 20;
  localparam int DATA_W    = 32;
  localparam int RES_DEPTH = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              cmd_valid, cmd_ready, cmd_rw;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_data;
  logic              RW, sel;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] din, dout;
  logic              bus_stop, pushout;
  logic              res_valid, res_ready;
  logic [DATA_W-1:0] res_data;
  logic              res_overflow, busy;

  int unsigned total = 0;
  int unsigned bad   = 0;

  // Reference model: the outstanding bus transaction and the result queue.
  logic              m_sel, m_rw;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_din;
  logic              m_ovf;
  logic [DATA_W-1:0] m_q[$];

  always #5 clk = ~clk;

  nn_bus_master #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .RES_DEPTH(RES_DEPTH)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_rw      (cmd_rw),
    .cmd_addr    (cmd_addr),
    .cmd_data    (cmd_data),
    .RW          (RW),
    .sel         (sel),
    .addr        (addr),
    .din         (din),
    .dout        (dout),
    .bus_stop    (bus_stop),
    .pushout     (pushout),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_data    (res_data),
    .res_overflow(res_overflow),
    .busy        (busy)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive inputs, compare against the model, advance the model.
  task automatic cyc(input logic rst, input logic cv, input logic rw,
                     input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                     input logic bs, input logic po, input logic [DATA_W-1:0] dv,
                     input logic rr);
    logic exp_ready, do_pop, was_full;
    reset = rst; cmd_valid = cv; cmd_rw = rw; cmd_addr = a; cmd_data = d;
    bus_stop = bs; pushout = po; dout = dv; res_ready = rr;
    #2;
    exp_ready = !rst && ((RES_DEPTH - m_q.size()) >= 2) && (!m_sel || !bs);
    check("cmd_ready", 64'(cmd_ready), 64'(exp_ready));
    check("sel", 64'(sel), 64'(m_sel));
    check("RW", 64'(RW), 64'(m_rw));
    check("addr", 64'(addr), 64'(m_addr));
    check("din", 64'(din), 64'(m_din));
    check("res_valid", 64'(res_valid), 64'(m_q.size() != 0));
    check("res_overflow", 64'(res_overflow), 64'(m_ovf));
    check("busy", 64'(busy), 64'(m_sel || (m_q.size() != 0)));
    if (m_q.size() != 0) check("res_data", 64'(res_data), 64'(m_q[0]));
    if (rst) begin
      m_sel = 1'b0; m_rw = 1'b0; m_addr = '0; m_din = '0; m_ovf = 1'b0;
      m_q.delete();
    end else begin
      was_full = (m_q.size() == RES_DEPTH);
      do_pop   = rr && (m_q.size() != 0);
      if (do_pop) void'(m_q.pop_front());
      if (po) begin
        if (!was_full || do_pop) m_q.push_back(dv);
        else m_ovf = 1'b1;
      end
      if (cv && exp_ready) begin
        m_sel = 1'b1; m_rw = rw; m_addr = a; m_din = rw ? d : '0;
      end else if (m_sel && !bs) begin
        m_sel = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) cyc(0, 0, 0, '0, '0, 0, 0, '0, 0);
  endtask

  task automatic do_reset();
    cyc(1, 1, 1, 20'h12345, 32'h55AA55AA, 1, 1, 32'h77, 1);
    cyc(1, 0, 0, '0, '0, 0, 0, '0, 0);
  endtask

  initial begin
    m_sel = 1'b0; m_rw = 1'b0; m_addr = '0; m_din = '0; m_ovf = 1'b0;
    reset = 1'b1; cmd_valid = 0; cmd_rw = 0; cmd_addr = '0; cmd_data = '0;
    bus_stop = 0; pushout = 0; dout = '0; res_ready = 0;
    @(posedge clk); #1;
    do_reset();
    idle(1);

    // Single write.
    cyc(0, 1, 1, 20'h00010, 32'hDEADBEEF, 0, 0, '0, 0);
    check("wr_sel", 64'(sel), 64'd1);
    check("wr_din", 64'(din), 64'hDEADBEEF);
    idle(2);
    check("wr_sel_off", 64'(sel), 64'd0);

    // Read stalled three cycles.
    cyc(0, 1, 0, 20'hFFFFF, 32'h11111111, 0, 0, '0, 0);
    for (int unsigned i = 0; i < 3; i++) cyc(0, 1, 1, 20'h00001, 32'h1, 1, 0, '0, 0);
    cyc(0, 0, 0, '0, '0, 0, 0, '0, 0);
    check("rd_done_sel", 64'(sel), 64'd0);
    check("rd_addr_hold", 64'(addr), 64'hFFFFF);
    idle(1);

    // Four back-to-back writes.
    for (int unsigned i = 1; i <= 4; i++)
      cyc(0, 1, 1, ADDR_W'(i), 32'hC0 + i, 0, 0, '0, 0);
    check("b2b_addr4", 64'(addr), 64'd4);
    idle(2);

    // Five pushouts into a four-deep FIFO, then drain.
    for (int unsigned i = 0; i < 5; i++) cyc(0, 0, 0, '0, '0, 0, 1, 32'hA0 + i, 0);
    check("ovf_set", 64'(res_overflow), 64'd1);
    check("ovf_ready", 64'(cmd_ready), 64'd0);
    for (int unsigned i = 0; i < 4; i++) begin
      check("drain", 64'(res_data), 64'(32'hA0 + i));
      cyc(0, 0, 0, '0, '0, 0, 0, '0, 1);
    end
    idle(1);

    // Full FIFO with simultaneous push and pop.
    do_reset();
    for (int unsigned i = 0; i < 4; i++) cyc(0, 0, 0, '0, '0, 0, 1, 32'hB0 + i, 0);
    cyc(0, 0, 0, '0, '0, 0, 1, 32'hB4, 1);
    check("pp_head", 64'(res_data), 64'hB1);
    check("pp_ovf", 64'(res_overflow), 64'd0);
    for (int unsigned i = 0; i < 5; i++) cyc(0, 0, 0, '0, '0, 0, 0, '0, 1);
    // Empty FIFO: push with res_ready must not pop.
    cyc(0, 0, 0, '0, '0, 0, 1, 32'hE1, 1);
    check("empty_pp", 64'(res_data), 64'hE1);
    idle(1);

    // Reset during a stalled transaction.
    cyc(0, 1, 1, 20'h0ABCD, 32'h12345678, 0, 1, 32'h99, 0);
    cyc(0, 0, 0, '0, '0, 1, 0, '0, 0);
    cyc(1, 1, 0, 20'h1, 32'h1, 1, 1, 32'h5, 1);
    check("rst_sel", 64'(sel), 64'd0);
    check("rst_valid", 64'(res_valid), 64'd0);
    idle(2);

    // Randomized traffic.
    for (int unsigned i = 0; i < 3000; i++) begin
      cyc(($urandom % 97) == 0, ($urandom % 2) == 0, $urandom % 2,
          ADDR_W'($urandom), $urandom, ($urandom % 10) < 3, ($urandom % 10) < 4,
          $urandom, ($urandom % 10) < 4);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
